lcd_timing_gen: RTL

- Parametrised LCD/RGB timing generator for the Gowin LCD examples.
- Produces HSYNC/VSYNC/DE and pixel coordinates for any panel geometry and sync polarity.
- Aligns an upstream pixel source of configurable read latency, with an optional built-in test-pattern generator.
- Sits between the PLL pixel clock domain and the panel pins; replaces hand-written per-panel counters.

---
 rtl/lcd_timing_gen.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/lcd_timing_gen.sv
// LCD/RGB timing generator: HSYNC/VSYNC/DE, pixel coordinates and latency-aligned RGB.
// Define LCD_TIMING_PATTERN_EN to build the colour-bar/checker/gradient test patterns.
module lcd_timing_gen #(
    parameter int H_ACTIVE  = 480,
    parameter int H_PULSE   = 4,
    parameter int H_BACK    = 43,
    parameter int H_FRONT   = 8,
    parameter int V_ACTIVE  = 272,
    parameter int V_PULSE   = 4,
    parameter int V_BACK    = 12,
    parameter int V_FRONT   = 8,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CNT_W     = 12,
    parameter int DATA_LAT  = 1,
    parameter int BAR_SHIFT = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic [1:0]       mode,
    input  logic [15:0]      rgb_in,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    output logic             req,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             frame_start,
    output logic [4:0]       lcd_r,
    output logic [5:0]       lcd_g,
    output logic [4:0]       lcd_b
);

    localparam int H_TOTAL = H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_BACK + V_ACTIVE + V_FRONT;
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_B    = CNT_W'(H_BACK);
    localparam logic [CNT_W-1:0] H_END  = CNT_W'(H_BACK + H_ACTIVE);
    localparam logic [CNT_W-1:0] V_B    = CNT_W'(V_BACK);
    localparam logic [CNT_W-1:0] V_END  = CNT_W'(V_BACK + V_ACTIVE);
    localparam logic [CNT_W-1:0] H_PW   = CNT_W'(H_PULSE);
    localparam logic [CNT_W-1:0] V_PW   = CNT_W'(V_PULSE);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);
`ifdef LCD_TIMING_PATTERN_EN
    localparam int XY_D = DATA_LAT;
`else
    localparam int XY_D = 0;
`endif

    logic [CNT_W-1:0] h, v;
    logic act_c, hs_c, vs_c, fs_c;
    logic [DATA_LAT:0] hs_p, vs_p, act_p, fs_p;
    logic [CNT_W-1:0] x_p [XY_D:0];
    logic [CNT_W-1:0] y_p [XY_D:0];
    logic [15:0] colour;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (ce) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + ONE;
            end else begin
                h <= h + ONE;
            end
        end
    end

    always_comb begin
        act_c = (h >= H_B) && (h < H_END) && (v >= V_B) && (v < V_END);
        hs_c  = (h < H_PW);
        vs_c  = (v < V_PW);
        fs_c  = (h == '0) && (v == '0);
    end

    // Index 0 is the x/y stage; index DATA_LAT feeds the output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_p  <= '0;
            vs_p  <= '0;
            act_p <= '0;
            fs_p  <= '0;
            for (int i = 0; i <= XY_D; i++) begin
                x_p[i] <= '0;
                y_p[i] <= '0;
            end
        end else if (ce) begin
            hs_p[0]  <= hs_c;
            vs_p[0]  <= vs_c;
            act_p[0] <= act_c;
            fs_p[0]  <= fs_c;
            x_p[0]   <= act_c ? h - H_B : '0;
            y_p[0]   <= act_c ? v - V_B : '0;
            for (int i = 1; i <= DATA_LAT; i++) begin
                hs_p[i]  <= hs_p[i-1];
                vs_p[i]  <= vs_p[i-1];
                act_p[i] <= act_p[i-1];
                fs_p[i]  <= fs_p[i-1];
            end
            for (int i = 1; i <= XY_D; i++) begin
                x_p[i] <= x_p[i-1];
                y_p[i] <= y_p[i-1];
            end
        end
    end

    // req is a fetch strobe with no backpressure: upstream must present the
    // pixel for this x/y on rgb_in exactly DATA_LAT ce-cycles later.
    assign x   = x_p[0];
    assign y   = y_p[0];
    assign req = act_p[0];

`ifdef LCD_TIMING_PATTERN_EN
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] pat_x, pat_y, bar;
    logic [2:0]       bar_idx;
    logic [4:0]       grad_b;
    logic             unused_hi;

    always_ff @(posedge clk) begin
        if (reset) mode_q <= 2'd0;
        else if (ce && fs_c) mode_q <= mode;
    end

    assign pat_x     = x_p[XY_D];
    assign pat_y     = y_p[XY_D];
    assign bar       = pat_x >> BAR_SHIFT;
    assign bar_idx   = (bar > CNT_W'(7)) ? 3'd7 : bar[2:0];
    assign grad_b    = 5'((pat_x[8:0] + pat_y[8:0]) >> 4);
    assign unused_hi = ^pat_y[CNT_W-1:9];

    always_comb begin
        colour = rgb_in;
        case (mode_q)
            2'd1: colour = {{5{bar_idx[2]}}, {6{bar_idx[1]}}, {5{bar_idx[0]}}};
            2'd2: colour = (pat_x[4] ^ pat_y[4]) ? 16'hFFFF : 16'h0000;
            2'd3: colour = {pat_x[7:3], pat_y[7:2], grad_b};
            default: colour = rgb_in;
        endcase
    end
`else
    logic unused_mode;
    assign unused_mode = ^mode;
    assign colour      = rgb_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            de          <= 1'b0;
            frame_start <= 1'b0;
            {lcd_r, lcd_g, lcd_b} <= 16'h0;
        end else if (ce) begin
            hsync       <= hs_p[DATA_LAT] ? HS_ON : ~HS_ON;
            vsync       <= vs_p[DATA_LAT] ? VS_ON : ~VS_ON;
            de          <= act_p[DATA_LAT];
            frame_start <= fs_p[DATA_LAT];
            {lcd_r, lcd_g, lcd_b} <= act_p[DATA_LAT] ? colour : 16'h0;
        end
    end

endmodule
